// File: rtl/seg7_multi_digit_counter.sv
// N-digit BCD up/down counter on a programmable prescaler tick, driving a
// time-multiplexed 7-segment display. Option: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_multi_digit_counter #(
    parameter int          NUM_DIGITS = 4,
    parameter logic [23:0] MAX_COUNT  = 24'd10_000_000,
    parameter int          SCAN_BITS  = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              rate,
    input  logic                    enable,
    input  logic                    down,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    wrap,
    output logic [6:0]              segments,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    dp
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [23:0]               presc_q, presc_d, compare;
    logic                      tick;
    logic [4*NUM_DIGITS-1:0]   digits_q, digits_d, stepped;
    logic                      wrap_q, wrap_d, all_limit;
    logic [NUM_DIGITS-1:0]     is_nine, is_zero, sel_d;
    logic [SCAN_BITS-1:0]      scan_q, scan_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [3:0]                cur_digit;
    logic [6:0]                seg_d, seg_q;
    logic [NUM_DIGITS-1:0]     sel_q;
    logic                      dp_d, dp_q;

    // A lowered rate leaves the prescaler above the new compare; >= fires at once.
    assign compare = (rate == 8'd0) ? MAX_COUNT : {6'b0, rate, 10'b0};
    assign tick    = enable && (presc_q >= compare);

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign is_nine[gi] = (digits_q[4*gi +: 4] == 4'd9);
            assign is_zero[gi] = (digits_q[4*gi +: 4] == 4'd0);
            assign sel_d[gi]   = (idx_q == IDX_W'(gi));
        end
    endgenerate

    // Ripple the carry/borrow from the LSD; surviving past the MSD means a wrap.
    always_comb begin
        logic carry;
        carry   = 1'b1;
        stepped = digits_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (down ? is_zero[i] : is_nine[i]) begin
                    stepped[4*i +: 4] = down ? 4'd9 : 4'd0;
                end else begin
                    stepped[4*i +: 4] = down ? digits_q[4*i +: 4] - 4'd1
                                             : digits_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        all_limit = carry;
    end

    always_comb begin
        presc_d  = presc_q;
        digits_d = digits_q;
        wrap_d   = 1'b0;
        if (clear) begin
            presc_d  = '0;
            digits_d = '0;
        end else if (enable) begin
            presc_d = tick ? 24'd0 : presc_q + 24'd1;
            if (tick) begin
                digits_d = stepped;
                wrap_d   = all_limit;
            end
        end
    end

    always_comb begin
        scan_d = scan_q + SCAN_BITS'(1);
        idx_d  = idx_q;
        if (&scan_q) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    assign cur_digit = digits_q[4*idx_q +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] zero_above;
    always_comb begin
        logic acc;
        acc = 1'b1;
        zero_above = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc = acc && is_zero[i];
            zero_above[i] = acc;
        end
    end
`endif

    always_comb begin
        case (cur_digit)
            4'd0:    seg_d = 7'h3F;
            4'd1:    seg_d = 7'h06;
            4'd2:    seg_d = 7'h5B;
            4'd3:    seg_d = 7'h4F;
            4'd4:    seg_d = 7'h66;
            4'd5:    seg_d = 7'h6D;
            4'd6:    seg_d = 7'h7D;
            4'd7:    seg_d = 7'h07;
            4'd8:    seg_d = 7'h7F;
            4'd9:    seg_d = 7'h6F;
            default: seg_d = 7'h00;
        endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if ((idx_q != '0) && zero_above[idx_q]) begin
            seg_d = 7'h00;
        end
`endif
    end

    assign dp_d = (idx_q == '0) && !enable;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q  <= '0;
            digits_q <= '0;
            wrap_q   <= 1'b0;
            scan_q   <= '0;
            idx_q    <= '0;
            seg_q    <= '0;
            sel_q    <= '0;
            dp_q     <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            digits_q <= digits_d;
            wrap_q   <= wrap_d;
            scan_q   <= scan_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            sel_q    <= sel_d;
            dp_q     <= dp_d;
        end
    end

    assign count_bcd = digits_q;
    assign wrap      = wrap_q;
    assign segments  = seg_q;
    assign digit_sel = sel_q;
    assign dp        = dp_q;

endmodule

// File: tb/tb_seg7_multi_digit_counter.sv
// Bench for seg7_multi_digit_counter: integer-arithmetic reference model,
// directed steps plus a randomized stretch, checked every cycle.
module tb_seg7_multi_digit_counter;

    localparam int ND  = 4;
    localparam int MC  = 4;
    localparam int SB  = 2;
    localparam int MOD = 10000;

    logic            clk = 1'b0;
    logic            reset, enable, down, clear;
    logic [7:0]      rate;
    logic [4*ND-1:0] count_bcd;
    logic            wrap, dp;
    logic [6:0]      segments;
    logic [ND-1:0]   digit_sel;

    int errors = 0;
    int checks = 0;

    int m_presc, m_count, m_wrap, m_scan, m_idx, m_seg, m_sel, m_dp;
    int seg_tab [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

    seg7_multi_digit_counter #(
        .NUM_DIGITS(ND),
        .MAX_COUNT (24'd4),
        .SCAN_BITS (SB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rate     (rate),
        .enable   (enable),
        .down     (down),
        .clear    (clear),
        .count_bcd(count_bcd),
        .wrap     (wrap),
        .segments (segments),
        .digit_sel(digit_sel),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    function automatic int pow10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [4*ND-1:0] to_bcd(input int v);
        logic [4*ND-1:0] b;
        for (int i = 0; i < ND; i++) b[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one clock edge, using the inputs present at the edge.
    task automatic model_edge();
        int s, cmp;
        bit tk;
        if (reset) begin
            m_presc = 0; m_count = 0; m_wrap = 0; m_scan = 0; m_idx = 0;
            m_seg = 0; m_sel = 0; m_dp = 0;
            return;
        end
        s = seg_tab[(m_count / pow10(m_idx)) % 10];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (m_idx > 0 && (m_count / pow10(m_idx)) == 0) s = 0;
`endif
        m_seg = s;
        m_sel = 1 << m_idx;
        m_dp  = (m_idx == 0 && !enable) ? 1 : 0;
        m_scan++;
        if (m_scan == (1 << SB)) begin
            m_scan = 0;
            m_idx  = (m_idx + 1) % ND;
        end
        cmp = (rate == 0) ? MC : int'(rate) * 1024;
        tk  = enable && (m_presc >= cmp);
        m_wrap = 0;
        if (clear) begin
            m_presc = 0;
            m_count = 0;
        end else if (enable) begin
            m_presc = tk ? 0 : m_presc + 1;
            if (tk) begin
                if (!down) begin
                    m_wrap  = (m_count == MOD - 1) ? 1 : 0;
                    m_count = (m_count + 1) % MOD;
                end else begin
                    m_wrap  = (m_count == 0) ? 1 : 0;
                    m_count = (m_count + MOD - 1) % MOD;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("count_bcd", 32'(count_bcd), 32'(to_bcd(m_count)));
        chk("wrap",      32'(wrap),      32'(m_wrap));
        chk("segments",  32'(segments),  32'(m_seg));
        chk("digit_sel", 32'(digit_sel), 32'(m_sel));
        chk("dp",        32'(dp),        32'(m_dp));
    endtask

    task automatic run_to(input int target, input string tag);
        for (int k = 0; k < 20000 && m_count != target; k++) step();
        chk(tag, 32'(count_bcd), 32'(to_bcd(target)));
    endtask

    function automatic int scan_seg(input int sel, input int d0, input int dhi);
        return (sel == 1) ? d0 : dhi;
    endfunction

    initial begin
        logic [4*ND-1:0] hold_exp;
        int exp_seg;

        reset = 1'b1; enable = 1'b0; down = 1'b0; clear = 1'b0; rate = 8'd0;
        repeat (3) step();
        chk("rst_count", 32'(count_bcd), 32'h0);
        chk("rst_seg",   32'(segments),  32'h0);
        chk("rst_sel",   32'(digit_sel), 32'h0);

        // Tick every 5 cycles from reset release.
        reset = 1'b0; enable = 1'b1;
        repeat (5) step();
        chk("first_tick", 32'(count_bcd), 32'h0001);
        repeat (45) step();
        chk("tenth_tick", 32'(count_bcd), 32'h0010);

        // Down from zero wraps to all nines, then up wraps back.
        clear = 1'b1; step(); clear = 1'b0;
        down = 1'b1;
        run_to(MOD - 1, "down_wrap_val");
        chk("down_wrap_pulse", 32'(wrap), 32'h1);
        step();
        chk("wrap_one_cycle", 32'(wrap), 32'h0);
        down = 1'b0;
        run_to(0, "up_wrap_val");
        chk("up_wrap_pulse", 32'(wrap), 32'h1);

        // Clear landing on a tick cycle at 9999 suppresses the wrap.
        down = 1'b1;
        run_to(MOD - 1, "reach_9999");
        down = 1'b0;
        for (int k = 0; k < 20 && m_presc < MC; k++) step();
        clear = 1'b1; step(); clear = 1'b0;
        chk("clear_on_tick_cnt",  32'(count_bcd), 32'h0);
        chk("clear_on_tick_wrap", 32'(wrap),      32'h0);

        // Slow rate then lower it mid-count: tick on the next cycle.
        rate = 8'd1; clear = 1'b1; step(); clear = 1'b0;
        repeat (600) step();
        chk("slow_no_tick", 32'(count_bcd), 32'h0);
        rate = 8'd0; step();
        chk("rate_lowered_tick", 32'(count_bcd), 32'h0001);
        rate = 8'd1;
        repeat (2100) step();
        chk("rate1_two_ticks", 32'(count_bcd), 32'h0003);
        rate = 8'd0;

        // Pause: count holds, dp marks digit 0.
        enable = 1'b0;
        hold_exp = to_bcd(m_count);
        repeat (100) step();
        chk("pause_hold", 32'(count_bcd), 32'(hold_exp));
        enable = 1'b1;

        // Randomized stretch.
        for (int k = 0; k < 3000; k++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) down = ~down;
            clear = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 299) == 0) rate = (rate == 8'd0) ? 8'd1 : 8'd0;
            step();
        end
        clear = 1'b0; rate = 8'd0; down = 1'b0; enable = 1'b1;

        // Scan check at 1234.
        clear = 1'b1; step(); clear = 1'b0;
        run_to(1234, "reach_1234");
        enable = 1'b0;
        repeat (2) step();
        for (int k = 0; k < 16; k++) begin
            step();
            case (m_sel)
                1: exp_seg = 'h66;
                2: exp_seg = 'h4F;
                4: exp_seg = 'h5B;
                default: exp_seg = 'h06;
            endcase
            chk("scan_1234", 32'(segments), 32'(exp_seg));
        end

        // Leading zeros at 0007.
        enable = 1'b1;
        clear = 1'b1; step(); clear = 1'b0;
        run_to(7, "reach_0007");
        enable = 1'b0;
        repeat (2) step();
        for (int k = 0; k < 16; k++) begin
            step();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            exp_seg = scan_seg(m_sel, 'h07, 'h00);
`else
            exp_seg = scan_seg(m_sel, 'h07, 'h3F);
`endif
            chk("scan_0007", 32'(segments), 32'(exp_seg));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_multi_digit_counter.md
Name: seg7_multi_digit_counter

Overview:
- Parametrised successor to the single-digit seconds counter: an N-digit BCD up/down counter advanced by a programmable prescaler tick.
- Drives a time-multiplexed seven-segment display: one digit lit per scan slot.
- Sits behind the top-level pin wrapper, which maps ui_in to the control inputs and uo_out/uio_out to the display and count outputs.

Parameters:
NUM_DIGITS, 4, number of BCD digits (legal range 1..6)
MAX_COUNT, 24'd10_000_000, prescaler compare value used when rate == 0; tick period = compare+1 clk cycles
SCAN_BITS, 10, each display scan slot lasts 2^SCAN_BITS clk cycles

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
rate  in  8  0 -> compare = MAX_COUNT; otherwise compare = {6'b0, rate, 10'b0}
enable  in  1  high: prescaler runs and the counter advances on ticks; low: both hold
down  in  1  0 = count up, 1 = count down; sampled on the tick cycle
clear  in  1  synchronous clear of prescaler and digits
count_bcd  out  4*NUM_DIGITS  registered digits; digit 0 = LSD in [3:0]
wrap  out  1  one-cycle pulse when the counter wraps
segments  out  7  active-high, bit0 = a .. bit6 = g, for the currently selected digit
digit_sel  out  NUM_DIGITS  one-hot active-high digit enable
dp  out  1  decimal point; high during digit 0's slot while enable == 0 (pause indicator)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port named reset.
- Reset state: prescaler = 0, all digits = 0, scan counter = 0, digit index = 0.
- Output reset values: count_bcd = 0, wrap = 0, segments = 7'h00, digit_sel = 0, dp = 0.
- Output timing: first registered display values appear on the cycle after reset is deasserted.
- Priority: reset > clear > tick.
- Prescaler is 24 bits. With enable high:
  - if prescaler >= compare: prescaler <= 0 and tick asserts that cycle;
  - else prescaler <= prescaler + 1.
  - The >= test handles rate being lowered mid-count: the tick fires on the next enabled cycle.
- Tick, up: BCD increment with carry chain; 9 -> 0 propagates a carry. All-9s -> all-0s wraps.
- Tick, down: BCD decrement with borrow chain; 0 -> 9 propagates a borrow. All-0s -> all-9s wraps.
- Update timing: count_bcd updates on the clock edge that ends the tick cycle. wrap is asserted in the same cycle the wrapped value first appears on count_bcd, for exactly 1 cycle.
- clear: prescaler = 0, digits = 0, wrap = 0 next cycle. clear overrides a coincident tick, so no wrap is produced.
- Scan counter:
  - SCAN_BITS wide, free-running, independent of enable and clear.
  - On overflow, the digit index increments; NUM_DIGITS-1 wraps to 0.
- Display outputs:
  - digit_sel = one-hot(index), registered.
  - segments = decode(digit[index]), registered.
  - dp is registered.
  - All three update together, 1 cycle after the index changes.
- Decode (gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10..15 decode to 00; they are unreachable.
- Segment values are taken from the registered digits, so a tick is visible on the display 2 cycles after the tick cycle.

Optional Feature:
SEG7_LEADING_ZERO_BLANK_EN
- Defined: while digit i is selected (i > 0) and it and every higher digit are 0, segments = 7'h00. digit_sel still asserts. Digit 0 is always shown.
- Undefined: all digits are displayed, including leading zeros.
- count_bcd and wrap are identical in both builds.

Test Plan:
1. MAX_COUNT=4, rate=0, enable=1 from reset release -> count_bcd = 16'h0001 after 5 cycles; 16'h0010 after 50 cycles.
2. NUM_DIGITS=2, up, counter at 8'h99, next tick -> count_bcd = 8'h00, wrap high exactly 1 cycle.
3. NUM_DIGITS=2, down=1, counter at 8'h00, tick -> 8'h99 and wrap pulse; next tick -> 8'h98, no wrap.
4. Rate handling:
   - rate=8'h01 -> ticks every 1025 cycles.
   - With the prescaler at 600, switch rate to 0 with MAX_COUNT=4 -> tick on the next cycle, prescaler back to 0.
5. clear asserted on a tick cycle with counter at 16'h9999, up -> count_bcd = 0, wrap stays 0. enable=0 for 100 cycles -> count holds and dp high in digit 0's slot.
6. Scan check, SCAN_BITS=2, count 16'h1234:
   - digit_sel cycles 0001/0010/0100/1000 every 4 cycles with segments 66/4F/5B/06.
   - With the macro defined and count 16'h0007: segments 07/00/00/00.
